// File: rtl/mac512_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// Module   : mac512_pkg
// Brief    : Shared constants, FSM state type and helpers for the
//            MAC_512 wide-add sequencer.
// Revision : 1.0 - initial release
// =====================================================================
package mac512_pkg;

   localparam int SLICE_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-slice build still needs a 1-bit index to stay legal
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cla64.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// Module   : cla64
// Brief    : 64-bit carry-lookahead adder, 4-bit groups with
//            group-level propagate/generate and block P/G outputs.
// Revision : 1.0 - initial release
// =====================================================================
module cla64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] s,
   output logic        cout,
   output logic        pout,
   output logic        gout
);

   logic [63:0] w_g;
   logic [63:0] w_p;
   logic [63:0] w_c;
   logic [15:0] w_gg;
   logic [15:0] w_gp;
   logic [16:0] w_gc;

   assign w_g     = a & b;
   assign w_p     = a ^ b;
   assign w_gc[0] = cin;

   generate
      for (genvar i = 0; i < 16; i++) begin : g_grp
         assign w_gg[i] = w_g[4*i+3]
                        | (w_p[4*i+3] & w_g[4*i+2])
                        | (w_p[4*i+3] & w_p[4*i+2] & w_g[4*i+1])
                        | (w_p[4*i+3] & w_p[4*i+2] & w_p[4*i+1] & w_g[4*i]);
         assign w_gp[i] = &w_p[4*i +: 4];

         assign w_c[4*i]   = w_gc[i];
         assign w_c[4*i+1] = w_g[4*i] | (w_p[4*i] & w_gc[i]);
         assign w_c[4*i+2] = w_g[4*i+1] | (w_p[4*i+1] & w_g[4*i])
                           | (w_p[4*i+1] & w_p[4*i] & w_gc[i]);
         assign w_c[4*i+3] = w_g[4*i+2] | (w_p[4*i+2] & w_g[4*i+1])
                           | (w_p[4*i+2] & w_p[4*i+1] & w_g[4*i])
                           | (w_p[4*i+2] & w_p[4*i+1] & w_p[4*i] & w_gc[i]);

         assign w_gc[i+1] = w_gg[i] | (w_gp[i] & w_gc[i]);
      end
   endgenerate

   assign s    = w_p ^ w_c;
   assign cout = w_gc[16];
   assign pout = &w_gp;
   // Full propagate excludes generate, so the block generate is cout without the cin path
   assign gout = w_gc[16] & ~pout;

endmodule

`default_nettype wire

// File: rtl/mac512_add_seq.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// Module   : mac512_add_seq
// Brief    : Multi-cycle 64*NSLICE-bit adder reusing one CLA64 slice,
//            LSB slice first, carry held in a register between slices.
// Config   : MAC512_ADD_SUB_EN adds the sub port (a-b via ~b and carry 1)
// Revision : 1.0 - initial release
// =====================================================================
module mac512_add_seq
   import mac512_pkg::*;
#(
   parameter int NSLICE = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SLICE_W*NSLICE-1:0] a,
   input  logic [SLICE_W*NSLICE-1:0] b,
   input  logic                      cin,
`ifdef MAC512_ADD_SUB_EN
   input  logic                      sub,
`endif
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SLICE_W*NSLICE-1:0] sum,
   output logic                      cout,
   output logic                      busy
);

   localparam int              c_w    = SLICE_W * NSLICE;
   localparam int              c_iw   = idx_width(NSLICE);
   localparam logic [c_iw-1:0] c_last = c_iw'(NSLICE - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_iw-1:0]     r_idx;
   logic                r_carry;
   logic [c_w-1:0]      r_a;
   logic [c_w-1:0]      r_b;
   logic [c_w-1:0]      r_sum;
   logic                r_cout;
   logic [31:0]         w_base;
   logic [SLICE_W-1:0]  w_a_sl;
   logic [SLICE_W-1:0]  w_b_sl;
   logic [SLICE_W-1:0]  w_s;
   logic                w_c;

`ifdef MAC512_ADD_SUB_EN
   logic                r_sub;
`endif

   assign w_base = 32'(r_idx) * 32'(SLICE_W);
   assign w_a_sl = r_a[w_base +: SLICE_W];
`ifdef MAC512_ADD_SUB_EN
   assign w_b_sl = r_b[w_base +: SLICE_W] ^ {SLICE_W{r_sub}};
`else
   assign w_b_sl = r_b[w_base +: SLICE_W];
`endif

   cla64 u_cla64 (
      .a    (w_a_sl),
      .b    (w_b_sl),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c),
      .pout (),
      .gout ()
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (r_idx == c_last) w_state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef MAC512_ADD_SUB_EN
         r_sub   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_idx <= '0;
`ifdef MAC512_ADD_SUB_EN
                  r_sub   <= sub;
                  r_carry <= sub | cin;
`else
                  r_carry <= cin;
`endif
               end
            end
            RUN: begin
               r_sum[w_base +: SLICE_W] <= w_s;
               r_carry                  <= w_c;
               // Index parks on the last slice so it never wraps
               if (r_idx == c_last) begin
                  r_cout <= w_c;
               end else begin
                  r_idx <= r_idx + c_iw'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

`default_nettype wire
